// File: rtl/write_burst_sequencer_if.sv
// Command/configuration inputs and DQ/DQS control outputs of the write burst sequencer.
// The sequencer connects through the slave modport; the stimulus side uses master.
interface write_burst_sequencer_if #(
  parameter int LAT_WIDTH = 6
);
  logic                 i_enable;
  logic                 i_wr_cmd;
  logic [LAT_WIDTH-1:0] i_wr_latency;
  logic [5:0]           i_burst_length;
  logic [7:0]           i_pre_pattern;
  logic [2:0]           i_pre_cycle;
  logic [1:0]           i_post_cycle;
  logic                 i_crc_en;
  logic                 o_dqs_en;
  logic [1:0]           o_dqs_pattern;
  logic                 o_dq_en;
  logic                 o_crc_slot;
  logic [5:0]           o_beat_cnt;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_cmd_err;

  modport master (
    output i_enable, i_wr_cmd, i_wr_latency, i_burst_length,
    output i_pre_pattern, i_pre_cycle, i_post_cycle, i_crc_en,
    input  o_dqs_en, o_dqs_pattern, o_dq_en, o_crc_slot,
    input  o_beat_cnt, o_busy, o_done, o_cmd_err
  );

  modport slave (
    input  i_enable, i_wr_cmd, i_wr_latency, i_burst_length,
    input  i_pre_pattern, i_pre_cycle, i_post_cycle, i_crc_en,
    output o_dqs_en, o_dqs_pattern, o_dq_en, o_crc_slot,
    output o_beat_cnt, o_busy, o_done, o_cmd_err
  );
endinterface

// File: rtl/write_burst_sequencer.sv
// Write burst sequencer: latency wait, DQS preamble, data beats, optional CRC slot, postamble.
// Next-cycle outputs are decoded from the next state and registered, so every output is a flop.
module write_burst_sequencer #(
  parameter int LAT_WIDTH = 6
) (
  input logic                     i_clock,
  input logic                     i_reset,
  write_burst_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LATENCY   = 3'd1;
  localparam logic [2:0] ST_PREAMBLE  = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_CRC       = 3'd4;
  localparam logic [2:0] ST_POSTAMBLE = 3'd5;

  localparam int CW = (LAT_WIDTH + 1 > 5) ? LAT_WIDTH + 1 : 5;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [2:0] norm_pre(input logic [2:0] pre);
    if (pre == 3'd0) begin
      return 3'd1;
    end else if (pre > 3'd4) begin
      return 3'd4;
    end else begin
      return pre;
    end
  endfunction

  function automatic logic [5:0] norm_bl(input logic [5:0] bl);
    if (bl == 6'd8 || bl == 6'd32) begin
      return bl;
    end else begin
      return 6'd16;
    end
  endfunction

  // Latency length minus one; the difference is one bit wider so wl < pre shows as negative.
  function automatic logic [CW-1:0] lat_len_m1(input logic [LAT_WIDTH-1:0] wl, input logic [2:0] pre);
    logic [LAT_WIDTH:0] diff;
    diff = {1'b0, wl} - (LAT_WIDTH + 1)'(pre);
    if (diff[LAT_WIDTH] || diff == {(LAT_WIDTH + 1){1'b0}}) begin
      return CNT_ZERO;
    end else begin
      return CW'(diff) - CNT_ONE;
    end
  endfunction

  function automatic logic [1:0] pre_bits(input logic [7:0] pat, input logic [1:0] idx);
    case (idx)
      2'd0:    return pat[1:0];
      2'd1:    return pat[3:2];
      2'd2:    return pat[5:4];
      default: return pat[7:6];
    endcase
  endfunction

  logic [2:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [5:0]    beat_r;
  logic [7:0]    pre_pattern_r;
  logic [2:0]    pre_cycle_r;
  logic [5:0]    bl_r;
  logic [1:0]    post_r;
  logic          crc_r;
  logic          dqs_en_r;
  logic [1:0]    dqs_pat_r;
  logic          dq_en_r;
  logic          crc_slot_r;
  logic          busy_r;
  logic          done_r;
  logic          cmd_err_r;

  logic [2:0]    state_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic [5:0]    beat_nxt_s;
  logic          accept_s;
  logic          cmd_err_s;
  logic          dqs_en_s;
  logic [1:0]    dqs_pat_s;
  logic          dq_en_s;
  logic          crc_slot_s;
  logic          done_s;

  assign accept_s  = (state_r == ST_IDLE) && bus.i_wr_cmd && bus.i_enable;
  assign cmd_err_s = bus.i_wr_cmd && ((state_r != ST_IDLE) || !bus.i_enable);

  // Next state, per-state down counter and beat counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    beat_nxt_s  = beat_r;
    case (state_r)
      ST_IDLE: begin
        beat_nxt_s = 6'd0;
        if (accept_s) begin
          state_nxt_s = ST_LATENCY;
          cnt_nxt_s   = lat_len_m1(bus.i_wr_latency, norm_pre(bus.i_pre_cycle));
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      ST_LATENCY: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_PREAMBLE;
          cnt_nxt_s   = CW'(pre_cycle_r) - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_DATA;
          cnt_nxt_s   = CW'(bl_r[5:1]) - CNT_ONE;
          beat_nxt_s  = 6'd0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s  = cnt_r - CNT_ONE;
          beat_nxt_s = beat_r + 6'd2;
        end else if (crc_r) begin
          state_nxt_s = ST_CRC;
          cnt_nxt_s   = CNT_ZERO;
        end else if (post_r != 2'd0) begin
          state_nxt_s = ST_POSTAMBLE;
          cnt_nxt_s   = CW'(post_r) - CNT_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
          beat_nxt_s  = 6'd0;
        end
      end
      ST_CRC: begin
        if (post_r != 2'd0) begin
          state_nxt_s = ST_POSTAMBLE;
          cnt_nxt_s   = CW'(post_r) - CNT_ONE;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          beat_nxt_s  = 6'd0;
        end
      end
      ST_POSTAMBLE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_IDLE;
          beat_nxt_s  = 6'd0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        beat_nxt_s  = 6'd0;
      end
    endcase
  end

  // Output values for the upcoming clock; done marks the last clock before IDLE.
  always_comb begin
    dqs_en_s   = 1'b0;
    dqs_pat_s  = 2'b00;
    dq_en_s    = 1'b0;
    crc_slot_s = 1'b0;
    done_s     = 1'b0;
    case (state_nxt_s)
      ST_PREAMBLE: begin
        dqs_en_s  = 1'b1;
        dqs_pat_s = pre_bits(pre_pattern_r, cnt_nxt_s[1:0]);
      end
      ST_DATA: begin
        dqs_en_s  = 1'b1;
        dqs_pat_s = 2'b10;
        dq_en_s   = 1'b1;
        done_s    = (cnt_nxt_s == CNT_ZERO) && !crc_r && (post_r == 2'd0);
      end
      ST_CRC: begin
        dqs_en_s   = 1'b1;
        dqs_pat_s  = 2'b10;
        dq_en_s    = 1'b1;
        crc_slot_s = 1'b1;
        done_s     = (post_r == 2'd0);
      end
      ST_POSTAMBLE: begin
        dqs_en_s = 1'b1;
        done_s   = (cnt_nxt_s == CNT_ZERO);
      end
      default: begin
        dqs_en_s = 1'b0;
      end
    endcase
  end

  // Burst configuration, captured once per accepted command and normalised on capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pre_pattern_r <= 8'd0;
      pre_cycle_r   <= 3'd0;
      bl_r          <= 6'd0;
      post_r        <= 2'd0;
      crc_r         <= 1'b0;
    end else if (accept_s) begin
      pre_pattern_r <= bus.i_pre_pattern;
      pre_cycle_r   <= norm_pre(bus.i_pre_cycle);
      bl_r          <= norm_bl(bus.i_burst_length);
      post_r        <= bus.i_post_cycle;
      crc_r         <= bus.i_crc_en;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      beat_r     <= 6'd0;
      dqs_en_r   <= 1'b0;
      dqs_pat_r  <= 2'b00;
      dq_en_r    <= 1'b0;
      crc_slot_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cmd_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      beat_r     <= beat_nxt_s;
      dqs_en_r   <= dqs_en_s;
      dqs_pat_r  <= dqs_pat_s;
      dq_en_r    <= dq_en_s;
      crc_slot_r <= crc_slot_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= done_s;
      cmd_err_r  <= cmd_err_s;
    end
  end

  assign bus.o_dqs_en      = dqs_en_r;
  assign bus.o_dqs_pattern = dqs_pat_r;
  assign bus.o_dq_en       = dq_en_r;
  assign bus.o_crc_slot    = crc_slot_r;
  assign bus.o_beat_cnt    = beat_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_done        = done_r;
  assign bus.o_cmd_err     = cmd_err_r;

endmodule

// File: tb/tb_write_burst_sequencer.sv
// Directed bench: a table of burst configurations with hand-computed phase lengths and
// preamble sequences, plus hand-written reset, dropped-command and mid-burst reset sequences.
module tb_write_burst_sequencer;

  logic i_clock;
  logic i_reset;

  write_burst_sequencer_if #(.LAT_WIDTH(6)) bus ();

  write_burst_sequencer #(.LAT_WIDTH(6)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Packed view: {busy, dqs_en, dqs_pattern[1:0], dq_en, crc_slot, done, cmd_err, beat_cnt[5:0]}
  logic [13:0] act_s;
  assign act_s = {bus.o_busy, bus.o_dqs_en, bus.o_dqs_pattern, bus.o_dq_en, bus.o_crc_slot,
                  bus.o_done, bus.o_cmd_err, bus.o_beat_cnt};

  typedef struct {
    logic [5:0] wl;
    logic [5:0] bl;
    logic [2:0] pre;
    logic [7:0] pat;
    logic [1:0] post;
    logic       crc;
    int         lat;      // expected LATENCY clocks
    int         npre;     // expected PREAMBLE clocks
    int         ndata;    // expected DATA clocks
    int         ncrc;     // expected CRC clocks
    int         npost;    // expected POSTAMBLE clocks
    logic [7:0] seq;      // expected preamble DQS pairs, first clock in [7:6]
    int         err_cyc;  // cycle on which a second command is issued, -1 for none
    logic       drop_en;  // drop i_enable right after the burst starts
  } burst_vec_t;

  burst_vec_t vecs [7];
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [13:0] exp);
    n_vec++;
    if (act_s !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act_s, exp);
    end
  endtask

  function automatic logic [13:0] expect_at(input burst_vec_t v, input int c);
    logic       busy, dqs, dq, crc_s, done, err;
    logic [1:0] pat;
    logic [5:0] beat;
    logic [7:0] s;
    int p;
    busy  = 1'b1;
    dqs   = 1'b0;
    dq    = 1'b0;
    crc_s = 1'b0;
    pat   = 2'b00;
    beat  = 6'd0;
    done  = (c == v.lat + v.npre + v.ndata + v.ncrc + v.npost - 1);
    err   = (v.err_cyc >= 0) && (c == v.err_cyc + 1);
    p = c - v.lat;
    if (p >= 0 && p < v.npre) begin
      dqs = 1'b1;
      s   = v.seq << (2 * p);
      pat = s[7:6];
    end
    p = p - v.npre;
    if (p >= 0 && p < v.ndata) begin
      dqs  = 1'b1;
      dq   = 1'b1;
      pat  = 2'b10;
      beat = 6'(2 * p);
    end else if (p >= v.ndata) begin
      beat = 6'(2 * (v.ndata - 1));
      dqs  = 1'b1;
      if (p - v.ndata < v.ncrc) begin
        dq    = 1'b1;
        crc_s = 1'b1;
        pat   = 2'b10;
      end
    end
    return {busy, dqs, pat, dq, crc_s, done, err, beat};
  endfunction

  task automatic drive_cfg(input burst_vec_t v);
    bus.i_wr_latency   = v.wl;
    bus.i_burst_length = v.bl;
    bus.i_pre_pattern  = v.pat;
    bus.i_pre_cycle    = v.pre;
    bus.i_post_cycle   = v.post;
    bus.i_crc_en       = v.crc;
  endtask

  // Issues one command and checks every clock of the burst plus two idle clocks after it.
  task automatic run_burst(input int idx);
    burst_vec_t v;
    int total;
    v = vecs[idx];
    total = v.lat + v.npre + v.ndata + v.ncrc + v.npost;
    drive_cfg(v);
    bus.i_enable = 1'b1;
    bus.i_wr_cmd = 1'b1;
    for (int c = 0; c < total; c++) begin
      @(negedge i_clock);
      check($sformatf("vec%0d cyc%0d", idx, c), expect_at(v, c));
      bus.i_wr_cmd = (c == v.err_cyc);
      if (v.drop_en) bus.i_enable = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clock);
      check($sformatf("vec%0d idle%0d", idx, c), 14'd0);
    end
    bus.i_enable = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //          wl     bl     pre   pattern       post  crc   lat npre ndata ncrc npost seq          err  drop
    vecs[0] = '{6'd8,  6'd16, 3'd2, 8'b00001010, 2'd1, 1'b0, 6,  2,   8,    0,   1,    8'b10100000, -1, 1'b0};
    vecs[1] = '{6'd10, 6'd32, 3'd1, 8'b00000001, 2'd0, 1'b1, 9,  1,   16,   1,   0,    8'b01000000, -1, 1'b1};
    vecs[2] = '{6'd2,  6'd8,  3'd4, 8'b00011011, 2'd2, 1'b0, 1,  4,   4,    0,   2,    8'b00011011, -1, 1'b0};
    vecs[3] = '{6'd5,  6'd12, 3'd0, 8'b11100110, 2'd3, 1'b1, 4,  1,   8,    1,   3,    8'b10000000, -1, 1'b0};
    vecs[4] = '{6'd20, 6'd8,  3'd7, 8'b10011100, 2'd0, 1'b0, 16, 4,   4,    0,   0,    8'b10011100, -1, 1'b0};
    vecs[5] = '{6'd3,  6'd32, 3'd3, 8'b11100111, 2'd1, 1'b0, 1,  3,   16,   0,   1,    8'b10011100, -1, 1'b0};
    vecs[6] = '{6'd8,  6'd16, 3'd2, 8'b00001010, 2'd1, 1'b0, 6,  2,   8,    0,   1,    8'b10100000, 10, 1'b0};

    // Reset with a command present: outputs zero, command ignored.
    i_reset = 1'b1;
    drive_cfg(vecs[0]);
    bus.i_enable = 1'b1;
    bus.i_wr_cmd = 1'b1;
    repeat (2) @(posedge i_clock);
    @(negedge i_clock);
    check("reset_state", 14'd0);
    i_reset = 1'b0;
    bus.i_wr_cmd = 1'b0;
    @(negedge i_clock);
    check("cmd_during_reset", 14'd0);

    // Command with i_enable low is dropped and flagged for one clock.
    bus.i_enable = 1'b0;
    bus.i_wr_cmd = 1'b1;
    @(negedge i_clock);
    check("disabled_cmd_err", 14'h0040);
    bus.i_enable = 1'b1;
    bus.i_wr_cmd = 1'b0;
    @(negedge i_clock);
    check("disabled_cmd_clear", 14'd0);

    for (int i = 0; i < 7; i++) begin
      run_burst(i);
    end

    // Reset on the third DATA clock aborts the burst with no done pulse.
    drive_cfg(vecs[0]);
    bus.i_wr_cmd = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge i_clock);
      check($sformatf("abort cyc%0d", c), expect_at(vecs[0], c));
      bus.i_wr_cmd = 1'b0;
    end
    i_reset = 1'b1;
    @(negedge i_clock);
    check("abort_reset", 14'd0);
    i_reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clock);
      check($sformatf("abort_idle%0d", c), 14'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
